kb_event_queue: RTL

Sits between the PS/2 scancode decoder/debounce path and the VGA controller, in the 25 MHz pixel-clock domain. Consumes one scancode byte per strobe and parses PS/2 set-2 prefix sequences (E0 extended, F0 break) into single key events. Suppresses typematic repeats and buffers events in a small first-word-fall-through FIFO. The game controller pops events at its own pace, so no keystroke is lost while it is busy in a frame.

---
 rtl/kb_event_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/kb_event_queue.sv
// PS/2 set-2 scancode parser with a typematic repeat filter and a
// first-word-fall-through event FIFO for the game controller.
module kb_event_queue #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          CLK,
   input  logic          ARST,
   input  logic [7:0]    KBCODE,
   input  logic          KBSTROBE,
   input  logic          EVT_RD,
   output logic          EVT_VALID,
   output logic [7:0]    EVT_CODE,
   output logic          EVT_EXT,
   output logic          EVT_BREAK,
   output logic [AW:0]   COUNT,
   output logic          OVERFLOW,
   input  logic          CLR_OVF
);

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t         state;
   state_t         state_nxt;
   logic           ev_fire;
   logic           ev_ext;
   logic           ev_brk;
   logic           rf_valid;
   logic           rf_ext;
   logic [7:0]     rf_code;
   logic           rf_match;
   logic           push;
   logic           pop;
   logic           full;
   logic           wr_ok;
   logic           ovf_set;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           ovf;
   logic [9:0]     mem [DEPTH];

   always_comb begin
      state_nxt = state;
      ev_fire   = 1'b0;
      ev_ext    = (state == EXT) || (state == EXT_BRK);
      ev_brk    = (state == BRK) || (state == EXT_BRK);
      if (KBSTROBE) begin
         case (KBCODE)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = ev_ext ? EXT_BRK : BRK;
            8'h00, 8'hFF: state_nxt = IDLE;
            default: begin
               ev_fire   = 1'b1;
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Only a repeated make is suppressed; releases always go through.
   assign rf_match = rf_valid && (rf_ext == ev_ext) && (rf_code == KBCODE);
   assign push     = ev_fire && !(rf_match && !ev_brk);
   assign full     = (count == FULL_CNT);
   assign pop      = EVT_RD && (count != '0);
   assign wr_ok    = push && (!full || pop);
   assign ovf_set  = push && full && !pop;

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         state    <= IDLE;
         rf_valid <= 1'b0;
         rf_ext   <= 1'b0;
         rf_code  <= 8'h00;
      end else begin
         state <= state_nxt;
         if (ev_fire) begin
            if (!ev_brk) begin
               rf_valid <= 1'b1;
               rf_ext   <= ev_ext;
               rf_code  <= KBCODE;
            end else if (rf_match) begin
               rf_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= {ev_ext, ev_brk, KBCODE};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf_set)      ovf <= 1'b1;
         else if (CLR_OVF) ovf <= 1'b0;
      end
   end

   assign EVT_VALID = (count != '0);
   assign EVT_EXT   = mem[rd_ptr][9];
   assign EVT_BREAK = mem[rd_ptr][8];
   assign EVT_CODE  = mem[rd_ptr][7:0];
   assign COUNT     = count;
   assign OVERFLOW  = ovf;

endmodule
